udp_tx_pkt_gen: RTL

//  Local-source packetiser on the UDP transmit side: buffers 32-bit words from an on-board

---
 rtl/udp_tx_pkt_gen.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/udp_tx_pkt_gen.sv
// Local-source UDP packetiser: buffers producer words, then feeds the UDP transmit
// handshake with a full packet, or with a partial one after an idle timeout.
module udp_tx_pkt_gen #(
    parameter int PKT_WORDS   = 64,
    parameter int BUF_DEPTH   = 256,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic        eth_tx_clk,
    input  logic        rst_n,
    input  logic        src_valid,
    input  logic [31:0] src_data,
    output logic        src_ready,
    output logic        tx_start_en,
    output logic [15:0] tx_byte_num,
    input  logic        tx_req,
    output logic [31:0] tx_data,
    input  logic        tx_done,
    output logic        busy,
    output logic [15:0] pkt_cnt
);

    localparam int AW = $clog2(BUF_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_START, S_SEND} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [TW-1:0]   to_q, to_d;
    logic [15:0]     byte_num_q, byte_num_d;
    logic [31:0]     tx_data_q, tx_data_d;
    logic [15:0]     pkt_cnt_q;
    logic            pkt_inc;
    logic            accept;
    logic [31:0]     buf_mem [BUF_DEPTH];

    assign accept = src_valid && src_ready;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge eth_tx_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            to_q       <= '0;
            byte_num_q <= '0;
            tx_data_q  <= '0;
            pkt_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            to_q       <= to_d;
            byte_num_q <= byte_num_d;
            tx_data_q  <= tx_data_d;
            if (pkt_inc) pkt_cnt_q <= pkt_cnt_q + 16'd1;
        end
    end

    // NOTE: the buffer has no reset; its contents are only read below the
    // word count, so stale data is never delivered and the array maps to RAM.
    always_ff @(posedge eth_tx_clk) begin
        if (accept) buf_mem[wr_ptr_q] <= src_data;
    end

    // NOTE: every combinational output gets a default first, so no path
    // through the case statement leaves a signal unassigned (no latches).
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = S_FILL;
            S_FILL: begin
                if (accept && count_q == CW'(PKT_WORDS - 1))
                    state_d = S_START;
                else if (!accept && count_q != '0 && to_q == TW'(TIMEOUT_CYC))
                    state_d = S_START;
            end
            S_START: state_d = S_SEND;
            S_SEND:  if (tx_done) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        to_d       = to_q;
        byte_num_d = byte_num_q;
        tx_data_d  = tx_data_q;
        pkt_inc    = 1'b0;
        case (state_q)
            S_FILL: begin
                if (accept) begin
                    wr_ptr_d = wr_ptr_q + AW'(1);
                    count_d  = count_q + CW'(1);
                    to_d     = '0;
                end else if (to_q != TW'(TIMEOUT_CYC)) begin
                    to_d = to_q + TW'(1);
                end
                // Length is latched on the way into START so it is valid with the pulse.
                if (state_d == S_START) byte_num_d = 16'({count_d, 2'b00});
            end
            S_START: rd_ptr_d = '0;
            S_SEND: begin
                if (tx_req) begin
                    if (rd_ptr_q < count_q) begin
                        tx_data_d = buf_mem[rd_ptr_q[AW-1:0]];
                        rd_ptr_d  = rd_ptr_q + CW'(1);
                    end else begin
                        tx_data_d = '0;
                    end
                end
                if (tx_done) begin
                    pkt_inc = 1'b1;
                    count_d = '0;
                    wr_ptr_d = '0;
                    to_d    = '0;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        src_ready   = (state_q == S_FILL);
        tx_start_en = (state_q == S_START);
        busy        = (state_q == S_START) || (state_q == S_SEND);
    end

    assign tx_byte_num = byte_num_q;
    assign tx_data     = tx_data_q;
    assign pkt_cnt     = pkt_cnt_q;

endmodule
